// File: rtl/bounce_pkg.sv
// Shared types and constants for the contact-bounce emulator.
package bounce_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StBounce,
    StHold
  } state_e;

  localparam int unsigned LfsrW = 16;

  // x^16 + x^14 + x^13 + x^11 + 1 -> feedback from bits 15, 13, 12, 10
  localparam logic [LfsrW-1:0] LfsrTaps = 16'hB400;

  // An all-zero seed would lock the LFSR up.
  localparam logic [LfsrW-1:0] ZeroSeedSub = 16'h0001;

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR; loads seed (or a non-zero substitute) on reset.
module lfsr16
  import bounce_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [LfsrW-1:0] seed,
  output logic [LfsrW-1:0] q
);

  logic [LfsrW-1:0] q_q;
  logic             fb;

  assign fb = ^(q_q & LfsrTaps);

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q <= (seed == '0) ? ZeroSeedSub : seed;
    end else begin
      q_q <= {q_q[LfsrW-2:0], fb};
    end
  end

  assign q = q_q;

endmodule

// File: rtl/bounce_gen.sv
// Mechanical contact emulator: turns clean press levels into a bouncing output with
// pseudo-random toggle gaps, followed by a settle lockout.
module bounce_gen
  import bounce_pkg::*;
#(
  parameter int unsigned     BOUNCE_LEN = 40,
  parameter int unsigned     GAP_BW     = 3,
  parameter int unsigned     HOLD_LEN   = 16,
  parameter logic [LfsrW-1:0] SEED      = 16'hACE1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       press,
  input  logic       bounce_en,
  output logic       data,
  output logic       level,
  output logic       busy,
  output logic [7:0] edges
);

  localparam int unsigned WinW  = (BOUNCE_LEN > 1) ? $clog2(BOUNCE_LEN) : 1;
  localparam int unsigned HoldW = (HOLD_LEN > 1) ? $clog2(HOLD_LEN) : 1;
  localparam logic [WinW-1:0]  WinLoad  = WinW'(BOUNCE_LEN - 1);
  localparam logic [HoldW-1:0] HoldLoad = HoldW'(HOLD_LEN - 1);

  state_e            state_q, state_d;
  logic              data_q, data_d;
  logic              level_q, level_d;
  logic              target_q, target_d;
  logic [7:0]        edges_q, edges_d;
  logic [WinW-1:0]   win_q, win_d;
  logic [GAP_BW-1:0] gap_q, gap_d;
  logic [HoldW-1:0]  hold_q, hold_d;
  logic [LfsrW-1:0]  lfsr_q;
  logic [7:0]        edges_inc;
  logic              unused_lfsr;

  lfsr16 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .seed  (SEED),
    .q     (lfsr_q)
  );

  assign unused_lfsr = ^lfsr_q[LfsrW-1:GAP_BW];
  assign edges_inc   = (edges_q == 8'hFF) ? edges_q : edges_q + 8'd1;

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    level_d  = level_q;
    target_d = target_q;
    edges_d  = edges_q;
    win_d    = win_q;
    gap_d    = gap_q;
    hold_d   = hold_q;

    unique case (state_q)
      StIdle: begin
        if (press != level_q) begin
          if (!bounce_en) begin
            data_d  = press;
            level_d = press;
            edges_d = 8'd0;
          end else begin
            target_d = press;
            data_d   = press;
            edges_d  = 8'd1;
            win_d    = WinLoad;
            gap_d    = lfsr_q[GAP_BW-1:0];
            state_d  = StBounce;
          end
        end else begin
          data_d = level_q;
        end
      end

      StBounce: begin
        // Window expiry wins over a gap expiry landing on the same cycle.
        if (win_q == '0) begin
          data_d  = target_q;
          if (data_q != target_q) edges_d = edges_inc;
          level_d = target_q;
          hold_d  = HoldLoad;
          state_d = StHold;
        end else begin
          win_d = win_q - WinW'(1);
          if (gap_q == '0) begin
            data_d  = ~data_q;
            edges_d = edges_inc;
            gap_d   = lfsr_q[GAP_BW-1:0];
          end else begin
            gap_d = gap_q - GAP_BW'(1);
          end
        end
      end

      StHold: begin
        data_d = target_q;
        if (hold_q == '0) begin
          state_d = StIdle;
        end else begin
          hold_d = hold_q - HoldW'(1);
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      data_q   <= 1'b0;
      level_q  <= 1'b0;
      target_q <= 1'b0;
      edges_q  <= 8'd0;
      win_q    <= '0;
      gap_q    <= '0;
      hold_q   <= '0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      level_q  <= level_d;
      target_q <= target_d;
      edges_q  <= edges_d;
      win_q    <= win_d;
      gap_q    <= gap_d;
      hold_q   <= hold_d;
    end
  end

  assign data  = data_q;
  assign level = level_q;
  assign busy  = (state_q != StIdle);
  assign edges = edges_q;

endmodule

// File: tb/tb_bounce_gen.sv
// Randomized bench for bounce_gen: two instances (seeded and zero-seeded) checked every
// cycle against an event-schedule reference model.
module tb_bounce_gen;

  localparam int BL = 40;
  localparam int GW = 3;
  localparam int HL = 16;

  logic clk = 1'b0;
  logic reset, press, bounce_en;
  logic data_a, level_a, busy_a;
  logic [7:0] edges_a;
  logic data_z, level_z, busy_z;
  logic [7:0] edges_z;

  always #5 clk = ~clk;

  bounce_gen #(
    .BOUNCE_LEN (BL),
    .GAP_BW     (GW),
    .HOLD_LEN   (HL),
    .SEED       (16'hACE1)
  ) dut_a (
    .clk       (clk),
    .reset     (reset),
    .press     (press),
    .bounce_en (bounce_en),
    .data      (data_a),
    .level     (level_a),
    .busy      (busy_a),
    .edges     (edges_a)
  );

  bounce_gen #(
    .BOUNCE_LEN (BL),
    .GAP_BW     (GW),
    .HOLD_LEN   (HL),
    .SEED       (16'h0000)
  ) dut_z (
    .clk       (clk),
    .reset     (reset),
    .press     (press),
    .bounce_en (bounce_en),
    .data      (data_z),
    .level     (level_z),
    .busy      (busy_z),
    .edges     (edges_z)
  );

  // Model keeps an event schedule: start edge, next toggle edge, first idle edge.
  typedef struct {
    bit          data;
    bit          level;
    bit          busy;
    int          edges;
    bit          target;
    int          n0;
    int          next_toggle;
    int          idle_from;
    logic [15:0] lfsr;
  } model_t;

  model_t      m [2];
  logic [15:0] seed_eff [2];
  int          n;
  int          n_checks;
  int          n_errors;
  int          toggles_z;

  function automatic logic [15:0] lfsr_next(input logic [15:0] x);
    return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
  endfunction

  function automatic int sat_inc(input int v);
    return (v >= 255) ? 255 : v + 1;
  endfunction

  function automatic model_t model_step(input model_t s, input bit p, input bit be,
                                        input bit rst, input int cyc,
                                        input logic [15:0] seed);
    model_t r;
    int     g;
    r = s;
    if (rst) begin
      r.data = 0; r.level = 0; r.busy = 0; r.edges = 0; r.target = 0;
      r.n0 = 0; r.next_toggle = 0; r.idle_from = 0; r.lfsr = seed;
      return r;
    end
    g = int'(s.lfsr) % (1 << GW);
    if (cyc >= s.idle_from) begin
      r.busy = 0;
      if (p != s.level) begin
        if (!be) begin
          r.data = p; r.level = p; r.edges = 0;
        end else begin
          r.target = p; r.data = p; r.edges = 1; r.busy = 1;
          r.n0 = cyc;
          r.next_toggle = cyc + g + 1;
          r.idle_from = cyc + BL + HL + 1;
        end
      end
    end else begin
      if (cyc == s.n0 + BL) begin
        if (s.data != s.target) r.edges = sat_inc(s.edges);
        r.data = s.target;
        r.level = s.target;
      end else if (cyc < s.n0 + BL && cyc == s.next_toggle) begin
        r.data = !s.data;
        r.edges = sat_inc(s.edges);
        r.next_toggle = cyc + g + 1;
      end
      r.busy = (cyc + 1 < s.idle_from);
    end
    r.lfsr = lfsr_next(s.lfsr);
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s @cycle %0d: got %0d expected %0d", tag, n, got, exp);
    end
  endtask

  task automatic step(input bit p, input bit be, input bit rst);
    logic prev_z;
    press = p;
    bounce_en = be;
    reset = rst;
    prev_z = data_z;
    @(posedge clk);
    for (int i = 0; i < 2; i++) m[i] = model_step(m[i], p, be, rst, n, seed_eff[i]);
    n++;
    #1;
    if (!rst && busy_z && data_z !== prev_z) toggles_z++;
    check("a.data",  32'(data_a),  32'(m[0].data));
    check("a.level", 32'(level_a), 32'(m[0].level));
    check("a.busy",  32'(busy_a),  32'(m[0].busy));
    check("a.edges", 32'(edges_a), 32'(m[0].edges));
    check("z.data",  32'(data_z),  32'(m[1].data));
    check("z.level", 32'(level_z), 32'(m[1].level));
    check("z.busy",  32'(busy_z),  32'(m[1].busy));
    check("z.edges", 32'(edges_z), 32'(m[1].edges));
  endtask

  // Press, release early (ignored while busy), then reset partway into a second bounce.
  task automatic run_directed();
    repeat (3) step(0, 1, 1);
    repeat (20) step(0, 1, 0);
    repeat (10) step(1, 1, 0);
    repeat (110) step(0, 1, 0);
    check("odd_edges_after_event", 32'(edges_a % 2), 32'd1);
    repeat (5) step(1, 0, 0);
    check("clean_edges", 32'(edges_a), 32'd0);
    check("clean_level", 32'(level_a), 32'd1);
    repeat (20) step(0, 1, 0);
    step(1, 0, 0);
    repeat (60) step(1, 1, 0);
    step(0, 1, 0);
    repeat (20) step(0, 1, 0);
    step(0, 1, 1);
    check("reset_abort_busy", 32'(busy_a), 32'd0);
    repeat (10) step(0, 1, 0);
  endtask

  initial begin
    n = 0;
    n_checks = 0;
    n_errors = 0;
    toggles_z = 0;
    seed_eff[0] = 16'hACE1;
    seed_eff[1] = 16'h0001;
    for (int i = 0; i < 2; i++) m[i] = model_step(m[i], 0, 0, 1, 0, seed_eff[i]);
    press = 0;
    bounce_en = 1;
    reset = 1;

    run_directed();
    run_directed();
    check("zero_seed_toggles", 32'(toggles_z > 2), 32'd1);

    begin
      bit p, be, r;
      p = 0;
      be = 1;
      for (int c = 0; c < 4000; c++) begin
        if ($urandom_range(0, 15) == 0) p = !p;
        be = ($urandom_range(0, 7) != 0);
        r = ($urandom_range(0, 599) == 0);
        step(p, be, r);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
